// File: rtl/l1_meta_array.sv
// L1 metadata array: NSETS x NWAYS {tag, coh} entries, synchronous read/write ports,
// with a one-set-per-cycle reset sweep that clears every entry before requests are accepted.
package l1_meta_pkg;
  localparam int IDX_BITS = 6;
  localparam int NWAYS    = 4;
  localparam int TAG_BITS = 20;

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [1:0]          coh;
  } L1MetadataST;

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic [NWAYS-1:0]    way_en;
    logic [TAG_BITS-1:0] tag;
  } L1MetaReadReqST;

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic [NWAYS-1:0]    way_en;
    logic [TAG_BITS-1:0] tag;
    L1MetadataST         data;
  } L1MetaWriteReqST;
endpackage

module l1_meta_array #(
  parameter int IDX_BITS = l1_meta_pkg::IDX_BITS,
  parameter int NWAYS    = l1_meta_pkg::NWAYS
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 read_valid,
  output logic                                 read_ready,
  input  l1_meta_pkg::L1MetaReadReqST          read_bits,
  input  logic                                 write_valid,
  output logic                                 write_ready,
  input  l1_meta_pkg::L1MetaWriteReqST         write_bits,
  output l1_meta_pkg::L1MetadataST [NWAYS-1:0] resp,
  output logic                                 resp_valid,
  output logic                                 init_busy
);
  localparam int NSETS = 1 << IDX_BITS;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NSETS - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                               state_q, state_d;
  logic [IDX_BITS-1:0]                  rst_cnt_q, rst_cnt_d;
  l1_meta_pkg::L1MetadataST             mem_q [NSETS][NWAYS];
  l1_meta_pkg::L1MetadataST [NWAYS-1:0] resp_q;
  logic                                 resp_valid_q;

  logic [NWAYS-1:0]          mem_we;
  logic [IDX_BITS-1:0]       mem_widx;
  l1_meta_pkg::L1MetadataST  mem_wdata;
  logic                      read_fire;

  // Request fields that carry no meaning for this array.
  logic unused_req_bits;
  assign unused_req_bits = ^{read_bits.way_en, read_bits.tag, write_bits.tag};

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    read_ready  = 1'b0;
    write_ready = 1'b0;
    init_busy   = 1'b0;
    mem_we      = '0;
    mem_widx    = write_bits.idx;
    mem_wdata   = write_bits.data;
    unique case (state_q)
      ST_INIT: begin
        init_busy = 1'b1;
        mem_we    = {NWAYS{1'b1}};
        mem_widx  = rst_cnt_q;
        mem_wdata = '0;
        rst_cnt_d = rst_cnt_q + 1'b1;
        if (rst_cnt_q == LAST_IDX) state_d = ST_RUN;
      end
      ST_RUN: begin
        write_ready = 1'b1;
        read_ready  = !write_valid;  // writes win, so read and write never share a cycle
        if (write_valid) mem_we = write_bits.way_en;
      end
    endcase
    // No array update on a reset edge; the sweep that follows does the clearing.
    if (!reset_n) mem_we = '0;
  end

  assign read_fire = read_valid && read_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      rst_cnt_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      resp_valid_q <= read_fire;
      if (read_fire) begin
        for (int w = 0; w < NWAYS; w++) resp_q[w] <= mem_q[read_bits.idx][w];
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int w = 0; w < NWAYS; w++) begin
      if (mem_we[w]) mem_q[mem_widx][w] <= mem_wdata;
    end
  end

  assign resp       = resp_q;
  assign resp_valid = resp_valid_q;
endmodule

// File: tb/tb_l1_meta_array.sv
// Bench for l1_meta_array: directed vectors, a per-cycle array-level model check,
// and literal expectations for the reset sweep and the named read/write scenarios.
module tb_l1_meta_array;
  import l1_meta_pkg::*;
  localparam int NS = 64;
  localparam int NW = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic read_valid, write_valid, read_ready, write_ready, resp_valid, init_busy;
  L1MetaReadReqST           read_bits;
  L1MetaWriteReqST          write_bits;
  L1MetadataST [NW-1:0]     resp;

  int checks = 0;
  int errors = 0;

  l1_meta_array #(.IDX_BITS(6), .NWAYS(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .read_valid(read_valid), .read_ready(read_ready), .read_bits(read_bits),
    .write_valid(write_valid), .write_ready(write_ready), .write_bits(write_bits),
    .resp(resp), .resp_valid(resp_valid), .init_busy(init_busy)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: contents as a plain array, sweep as a countdown of remaining busy cycles.
  L1MetadataST          m_mem [NS][NW];
  L1MetadataST [NW-1:0] m_resp;
  bit                   m_valid;
  int                   m_sweep;
  bit                   armed = 1'b0;

  always @(posedge clock) begin
    if (!reset_n) begin
      armed   = 1'b1;
      m_sweep = NS;
      m_valid = 1'b0;
      m_resp  = '0;
      foreach (m_mem[s, w]) m_mem[s][w] = '0;
    end else if (m_sweep > 0) begin
      m_sweep--;
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (write_valid) begin
        for (int w = 0; w < NW; w++)
          if (write_bits.way_en[w]) m_mem[write_bits.idx][w] = write_bits.data;
      end else if (read_valid) begin
        m_valid = 1'b1;
        for (int w = 0; w < NW; w++) m_resp[w] = m_mem[read_bits.idx][w];
      end
    end
  end

  always @(negedge clock) begin
    if (armed && reset_n) begin
      chk("init_busy", init_busy, m_sweep > 0);
      chk("write_ready", write_ready, m_sweep == 0);
      chk("read_ready", read_ready, (m_sweep == 0) && !write_valid);
      chk("resp_valid", resp_valid, m_valid);
      chk("resp", resp, m_resp);
    end
  end

  task automatic drive(input bit rv, input int ridx, input bit wv, input int widx,
                       input logic [3:0] we, input logic [19:0] tag, input logic [1:0] coh);
    read_valid           = rv;
    read_bits.idx        = ridx[5:0];
    read_bits.way_en     = 4'hf;
    read_bits.tag        = 20'hfffff;
    write_valid          = wv;
    write_bits.idx       = widx[5:0];
    write_bits.way_en    = we;
    write_bits.tag       = 20'h0dead;
    write_bits.data.tag  = tag;
    write_bits.data.coh  = coh;
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 0, 4'h0, 20'h0, 2'b00);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sweep_len(input string nm);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (init_busy) n++;
      else done = 1'b1;
    end
    chk(nm, n, 64);
    tick();
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    chk("busy_after_release", init_busy, 1'b1);
    chk("ready_in_init", {read_ready, write_ready}, 2'b00);
    sweep_len("sweep_first");
    chk("ready_in_run", {read_ready, write_ready}, 2'b11);

    for (int i = 0; i < NS; i++) begin
      drive(1'b1, i, 1'b0, 0, 4'h0, 20'h0, 2'b00);
      tick();
    end
    idle();
    chk("resp_set63_zero", resp, 0);
    tick();

    // Single-way write then read of the same set on the next cycle.
    drive(1'b0, 0, 1'b1, 5, 4'b0010, 20'h12345, 2'b11);
    tick();
    drive(1'b1, 5, 1'b0, 0, 4'h0, 20'h0, 2'b00);
    tick();
    idle();
    chk("resp_valid_017", resp_valid, 1'b1);
    chk("resp_017_way1", resp[1], {20'h12345, 2'b11});
    chk("resp_017_others", {resp[3], resp[2], resp[0]}, 0);
    tick();
    chk("resp_valid_drop", resp_valid, 1'b0);
    chk("resp_hold", resp[1], {20'h12345, 2'b11});

    // Simultaneous read and write: the write takes the cycle.
    drive(1'b1, 9, 1'b1, 9, 4'hf, 20'h00abc, 2'b01);
    #2;
    chk("read_ready_blocked", read_ready, 1'b0);
    @(posedge clock);
    #1;
    drive(1'b1, 9, 1'b0, 0, 4'h0, 20'h0, 2'b00);
    tick();
    idle();
    chk("resp_018", resp, {4{{20'h00abc, 2'b01}}});

    // way_en = 0 is a no-op.
    drive(1'b0, 0, 1'b1, 7, 4'b0000, 20'hfffff, 2'b10);
    tick();
    drive(1'b1, 7, 1'b0, 0, 4'h0, 20'h0, 2'b00);
    tick();
    idle();
    chk("resp_019", resp, 0);

    // Distinct contents in sets 0..3, then back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 0, 1'b1, i, 4'(1 << i), 20'h00100 + 20'(i), 2'(i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i, 1'b0, 0, 4'h0, 20'h0, 2'b00);
      tick();
      chk("b2b_valid", resp_valid, 1'b1);
      chk("b2b_way_tag", resp[i].tag, 20'h00100 + 20'(i));
    end
    idle();
    tick();
    chk("b2b_valid_end", resp_valid, 1'b0);

    // Reset pulse mid-sweep restarts the whole sweep.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (20) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sweep_len("sweep_mid_restart");

    // Reset after a write and a read: response cleared, contents swept.
    drive(1'b0, 0, 1'b1, 5, 4'b0010, 20'h12345, 2'b11);
    tick();
    drive(1'b1, 5, 1'b0, 0, 4'h0, 20'h0, 2'b00);
    tick();
    idle();
    reset_n = 1'b0;
    tick();
    chk("reset_resp_valid", resp_valid, 1'b0);
    chk("reset_resp", resp, 0);
    reset_n = 1'b1;
    sweep_len("sweep_after_write");
    drive(1'b1, 5, 1'b0, 0, 4'h0, 20'h0, 2'b00);
    tick();
    idle();
    chk("resp_021_valid", resp_valid, 1'b1);
    chk("resp_021_way1", resp[1], 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/l1_meta_array.md
L1_META_ARRAY -- requirements
Module: l1_meta_array

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- IDX_BITS, HasL1CacheParameters::idxBits, set index width; NSETS = 2**IDX_BITS.
- NWAYS, HasL1CacheParameters::nWays, associativity.
- Entry type is HellaCacheST::L1MetadataST {tag, coh}; reset value {tag=0, coh=0 (Nothing)}.

REQ-002 Ports, one per line (name, direction, width, meaning); the block has one clock and a synchronous, active-low reset:
- clock, in, 1, sole clock; all state updates on its rising edge.
- reset_n, in, 1, synchronous, active-low reset.
- read_valid, in, 1, read request valid.
- read_ready, out, 1, read request accepted.
- read_bits, in, L1MetaReadReqST, {idx, way_en, tag}; way_en and tag ignored.
- write_valid, in, 1, write request valid.
- write_ready, out, 1, write request accepted.
- write_bits, in, L1MetaWriteReqST, {idx, way_en, tag, data}; only idx, way_en and data are used.
- resp, out, NWAYS x L1MetadataST, registered metadata of all ways of the read set.
- resp_valid, out, 1, resp is updated this cycle.
- init_busy, out, 1, reset sweep in progress.

Function
REQ-003 Storage: NSETS x NWAYS entries of L1MetadataST. Read port and write port are synchronous.
REQ-004 States: INIT and RUN. A 2-bit or 1-bit state register plus an IDX_BITS-wide sweep counter rst_cnt.
REQ-005 INIT behaviour, each cycle:
- write the reset value into all NWAYS entries of set rst_cnt;
- increment rst_cnt.
REQ-006 INIT to RUN: the transition happens in the cycle that writes rst_cnt == NSETS-1. The sweep takes exactly NSETS cycles and never stops early.
REQ-007 In INIT: read_ready=0, write_ready=0, init_busy=1, and no request fires.
REQ-008 In RUN:
- init_busy=0;
- write_ready=1;
- read_ready = !write_valid, so a write has strict priority and a read and a write never fire in the same cycle.
REQ-009 Write fire (write_valid && write_ready): for every way w with way_en[w]=1, entry[idx][w] <= data.
- way_en=0 is a legal no-op.
- Multiple bits set write all the selected ways.
REQ-010 Read fire (read_valid && read_ready): in the next cycle, resp[w] = entry[idx][w] for all w, and resp_valid=1.
- Latency is exactly 1 cycle.
- Back-to-back reads give back-to-back responses.
REQ-011 A read accepted in the cycle after a write to the same set returns the newly written data. No bypass is needed because the write completes at the clock edge.
REQ-012 resp_valid is high for exactly one cycle per read fire. When no read fires, resp holds its last value.
REQ-013 The valid-to-ready path is the only combinational path from inputs to outputs. resp is fully registered.

Reset
REQ-014 While reset_n=0 at a rising edge:
- state <= INIT, rst_cnt <= 0;
- resp <= 0, resp_valid <= 0;
- outputs read_ready=0, write_ready=0, init_busy=1.
REQ-015 Asserting reset mid-sweep or mid-operation restarts the full NSETS-cycle sweep.
- It drops any pending response.
- All previously written entries read back as the reset value after the sweep.

Verification
REQ-016 Reset release, IDX_BITS=6, NWAYS=4 -> init_busy=1 for exactly 64 cycles, then read_ready=1 and write_ready=1; reading idx 0..63 returns tag=0, coh=0 in all ways.
REQ-017 Write idx=5, way_en=4'b0010, data={tag=0x12345, coh=2'b11}, then read idx=5 next cycle -> one cycle later resp_valid=1, resp[1]={0x12345, 3}, ways 0/2/3 = {0, 0}.
REQ-018 read_valid and write_valid both high in RUN (read idx=9, write idx=9, way_en=4'b1111, coh=1) -> read_ready=0 and the write fires; the read fires next cycle and returns coh=1 in all 4 ways.
REQ-019 Write idx=7 with way_en=4'b0000 -> read idx=7 returns all zero; entry state is unchanged.
REQ-020 Reads of idx 0,1,2,3 on consecutive cycles -> resp_valid high for 4 consecutive cycles, with resp matching sets 0..3 in order.
REQ-021 reset_n pulsed low for 1 cycle when rst_cnt=20, and again after REQ-017's write -> full 64-cycle sweep both times; idx=5 way1 then reads {0, 0}.
